// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller for the 8-bit add/subtract unit.
// Owns the accumulator and Z/N/C/V flags, and issues one ALU op per handshake.
module alu_exec_ctrl #(
  parameter logic [7:0] ACC_INIT  = 8'h00,
  parameter logic [3:0] FLAG_INIT = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_opcode,
  input  logic [7:0] in_operand,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_op,
  input  logic [7:0] add_sd,
  input  logic       add_cb,
  input  logic       add_ov,
  output logic [7:0] acc,
  output logic [3:0] flags,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_INC = 3'b101;
  localparam logic [2:0] OP_DEC = 3'b110;

  logic [1:0] state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] flags_q, flags_d;
  logic [2:0] op_q, op_d;
  logic [7:0] opnd_q, opnd_d;
  logic       accept;
  logic       in_exec;
  logic [3:0] arith_flags;

  assign in_exec  = (state_q == S_EXEC);
  assign in_ready = ~in_exec;
  assign done     = (state_q == S_DONE);
  assign accept   = in_valid & in_ready;
  assign acc      = acc_q;
  assign flags    = flags_q;
  assign add_a    = acc_q;

  assign arith_flags = {add_sd == 8'h00, add_sd[7], add_cb, add_ov};

  // Sequencing: accept, execute for one cycle, then retire (or chain).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE:  state_d = in_valid ? S_EXEC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the instruction only on a handshake.
  always_comb begin
    op_d   = op_q;
    opnd_d = opnd_q;
    if (accept) begin
      op_d   = in_opcode;
      opnd_d = in_operand;
    end
  end

  // Adder operand/operator select; idle drive is acc + 0.
  always_comb begin
    add_b  = 8'h00;
    add_op = 1'b0;
    if (in_exec) begin
      case (op_q)
        OP_LDA, OP_ADD: add_b = opnd_q;
        OP_SUB, OP_CMP: begin
          add_b  = opnd_q;
          add_op = 1'b1;
        end
        OP_INC: add_b = 8'h01;
        OP_DEC: begin
          add_b  = 8'h01;
          add_op = 1'b1;
        end
        default: add_b = 8'h00;
      endcase
    end
  end

  // Result writeback happens only while leaving EXEC.
  always_comb begin
    acc_d   = acc_q;
    flags_d = flags_q;
    if (in_exec) begin
      case (op_q)
        OP_LDA: begin
          acc_d   = opnd_q;
          flags_d = {opnd_q == 8'h00, opnd_q[7], flags_q[1:0]};
        end
        OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
          acc_d   = add_sd;
          flags_d = arith_flags;
        end
        OP_CMP:  flags_d = arith_flags;
        default: flags_d = flags_q;
      endcase
    end
  end

  // State, datapath and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= ACC_INIT;
      flags_q <= FLAG_INIT;
      op_q    <= 3'b000;
      opnd_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Testbench for alu_exec_ctrl with a behavioural adder and
// an arithmetic reference model of acc/flags.
module tb_alu_exec_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opcode;
  logic [7:0] in_operand;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_op;
  logic [7:0] add_sd;
  logic       add_cb;
  logic       add_ov;
  logic [7:0] acc;
  logic [3:0] flags;
  logic       done;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] m_acc;
  logic [3:0] m_flags;

  alu_exec_ctrl #(.ACC_INIT(8'h00), .FLAG_INIT(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_operand(in_operand),
    .add_a(add_a), .add_b(add_b), .add_op(add_op),
    .add_sd(add_sd), .add_cb(add_cb), .add_ov(add_ov),
    .acc(acc), .flags(flags), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational adder the controller drives.
  int ra, rb, rs, sa, sb, ss;
  always_comb begin
    ra = int'(add_a);
    rb = int'(add_b);
    sa = int'($signed(add_a));
    sb = int'($signed(add_b));
    rs = add_op ? (ra - rb) : (ra + rb);
    ss = add_op ? (sa - sb) : (sa + sb);
    add_sd = rs[7:0];
    add_cb = add_op ? (ra >= rb) : (rs > 255);
    add_ov = (ss > 127) || (ss < -128);
  end

  task automatic model_step(input logic [2:0] op, input logic [7:0] d);
    int a, b, r, s1, s2, sr;
    logic [7:0] bb, res;
    logic sub, arith, c, v;
    a = int'(m_acc);
    bb = d;
    sub = 1'b0;
    arith = 1'b1;
    case (op)
      3'd1: begin
        m_acc = d;
        m_flags[3] = (d == 8'h00);
        m_flags[2] = d[7];
        arith = 1'b0;
      end
      3'd2: arith = 1'b1;
      3'd3, 3'd4: sub = 1'b1;
      3'd5: bb = 8'h01;
      3'd6: begin
        bb = 8'h01;
        sub = 1'b1;
      end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      b = int'(bb);
      s1 = int'($signed(m_acc));
      s2 = int'($signed(bb));
      r = sub ? a - b : a + b;
      sr = sub ? s1 - s2 : s1 + s2;
      res = r[7:0];
      c = sub ? (a >= b) : (r > 255);
      v = (sr > 127) || (sr < -128);
      if (op != 3'd4) m_acc = res;
      m_flags = {res == 8'h00, res[7], c, v};
    end
  endtask

  // Call at a negedge; returns negedges from accept edge to first done.
  task automatic issue(input logic [2:0] op, input logic [7:0] d,
                       output int lat);
    int w;
    lat = -1;
    in_valid = 1'b1;
    in_opcode = op;
    in_operand = d;
    w = 0;
    while (!in_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_opcode = 3'($urandom);
    in_operand = 8'($urandom);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_opcode = 3'd0;
    in_operand = 8'h00;
    m_acc = 8'h00;
    m_flags = 4'b0000;
    @(negedge clk);
    total_cnt++;
    if (acc !== 8'h00) $display("FAIL reset_acc got %h want 00", acc);
    else pass_cnt++;
    total_cnt++;
    if (flags !== 4'b0000) $display("FAIL reset_flags got %b want 0000", flags);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_hs got done=%b rdy=%b want 0/1", done, in_ready);
    else pass_cnt++;
    total_cnt++;
    if (add_b !== 8'h00 || add_op !== 1'b0)
      $display("FAIL reset_adder got b=%h op=%b want 00/0", add_b, add_op);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL post_reset_idle got rdy=%b done=%b want 1/0", in_ready, done);
    else pass_cnt++;
  endtask

  task automatic test_add_overflow;
    int lat;
    issue(3'd1, 8'h7F, lat);
    model_step(3'd1, 8'h7F);
    total_cnt++;
    if (lat !== 2) $display("FAIL lda_latency got %0d want 2", lat);
    else pass_cnt++;
    issue(3'd2, 8'h01, lat);
    model_step(3'd2, 8'h01);
    total_cnt++;
    if (lat !== 2) $display("FAIL add_latency got %0d want 2", lat);
    else pass_cnt++;
    total_cnt++;
    if (acc !== 8'h80 || flags !== 4'b0101)
      $display("FAIL add_ovf got acc=%h fl=%b want 80/0101", acc, flags);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL done_single got %b want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_sub;
    int lat;
    issue(3'd1, 8'h05, lat);
    model_step(3'd1, 8'h05);
    issue(3'd3, 8'h05, lat);
    model_step(3'd3, 8'h05);
    total_cnt++;
    if (acc !== 8'h00 || flags !== 4'b1010)
      $display("FAIL sub_zero got acc=%h fl=%b want 00/1010", acc, flags);
    else pass_cnt++;
    issue(3'd3, 8'h01, lat);
    model_step(3'd3, 8'h01);
    total_cnt++;
    if (acc !== 8'hFF || flags !== 4'b0100)
      $display("FAIL sub_borrow got acc=%h fl=%b want ff/0100", acc, flags);
    else pass_cnt++;
  endtask

  task automatic test_cmp;
    int lat;
    issue(3'd1, 8'h10, lat);
    model_step(3'd1, 8'h10);
    @(negedge clk);
    in_valid = 1'b1;
    in_opcode = 3'd4;
    in_operand = 8'h20;
    total_cnt++;
    if (add_op !== 1'b0) $display("FAIL cmp_op_idle got %b want 0", add_op);
    else pass_cnt++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (add_op !== 1'b1 || add_b !== 8'h20 || in_ready !== 1'b0)
      $display("FAIL cmp_exec got op=%b b=%h rdy=%b want 1/20/0",
               add_op, add_b, in_ready);
    else pass_cnt++;
    @(negedge clk);
    model_step(3'd4, 8'h20);
    total_cnt++;
    if (done !== 1'b1 || add_op !== 1'b0)
      $display("FAIL cmp_done got done=%b op=%b want 1/0", done, add_op);
    else pass_cnt++;
    total_cnt++;
    if (acc !== 8'h10 || flags !== 4'b0100)
      $display("FAIL cmp_result got acc=%h fl=%b want 10/0100", acc, flags);
    else pass_cnt++;
  endtask

  task automatic test_inc_dec;
    int lat;
    issue(3'd1, 8'hFF, lat);
    model_step(3'd1, 8'hFF);
    issue(3'd5, 8'h3C, lat);
    model_step(3'd5, 8'h3C);
    total_cnt++;
    if (acc !== 8'h00 || flags !== 4'b1010)
      $display("FAIL inc_wrap got acc=%h fl=%b want 00/1010", acc, flags);
    else pass_cnt++;
    issue(3'd6, 8'hA5, lat);
    model_step(3'd6, 8'hA5);
    total_cnt++;
    if (acc !== 8'hFF || flags !== 4'b0100)
      $display("FAIL dec_wrap got acc=%h fl=%b want ff/0100", acc, flags);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    int dones;
    logic exp_rdy;
    issue(3'd1, 8'h00, lat);
    model_step(3'd1, 8'h00);
    dones = 0;
    in_valid = 1'b1;
    in_opcode = 3'd2;
    in_operand = 8'h01;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = (k % 2 == 0);
      total_cnt++;
      if (in_ready !== exp_rdy)
        $display("FAIL b2b_ready k=%0d got %b want %b", k, in_ready, exp_rdy);
      else pass_cnt++;
      if (k > 0 && done === 1'b1) dones++;
      @(posedge clk);
      #1;
      if (k == 4) in_valid = 1'b0;
      @(negedge clk);
    end
    if (done === 1'b1) dones++;
    for (int k = 0; k < 3; k++) model_step(3'd2, 8'h01);
    total_cnt++;
    if (acc !== 8'h03 || dones !== 3)
      $display("FAIL b2b_result got acc=%h dones=%0d want 03/3", acc, dones);
    else pass_cnt++;
    total_cnt++;
    if (flags !== m_flags)
      $display("FAIL b2b_flags got %b want %b", flags, m_flags);
    else pass_cnt++;
  endtask

  task automatic test_random;
    int lat;
    logic [2:0] op;
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      issue(op, d, lat);
      model_step(op, d);
      total_cnt++;
      if (lat !== 2 || acc !== m_acc || flags !== m_flags)
        $display("FAIL rand_%0d op=%0d d=%h got lat=%0d acc=%h fl=%b want 2/%h/%b",
                 i, op, d, lat, acc, flags, m_acc, m_flags);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    int seen;
    issue(3'd1, 8'h22, lat);
    model_step(3'd1, 8'h22);
    in_valid = 1'b1;
    in_opcode = 3'd2;
    in_operand = 8'h10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (acc !== 8'h00 || flags !== 4'b0000)
      $display("FAIL abort_state got acc=%h fl=%b want 00/0000", acc, flags);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL abort_hs got done=%b rdy=%b want 0/1", done, in_ready);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    total_cnt++;
    if (seen !== 0 || acc !== 8'h00 || in_ready !== 1'b1)
      $display("FAIL abort_after got dones=%0d acc=%h rdy=%b want 0/00/1",
               seen, acc, in_ready);
    else pass_cnt++;
    m_acc = 8'h00;
    m_flags = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_cmp();
    test_inc_dec();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
